packet_gen: RTL and testbench

Synthetic traffic source that drives the ingress packet interface (`packet_in`/`packet_en`) with well-formed, block-aligned packets. It sits in front of each ingress port, in the same slot as the external traffic source, and is the transmitter for the ingress receiver. It emits a configurable number of packets of programmable length and destination, with a sequence number and a deterministic payload, so that packets can be checked end-to-end at egress.

---
 rtl/packet_gen.sv | 200 ++++++++++++++++++++
 tb/tb_packet_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_gen.sv
// Synthetic block-aligned packet source for an ingress port: header, MAC, sequence word, payload.
// Payload comes from a Galois LFSR when PKT_GEN_LFSR_EN is defined, otherwise it is {seq, word index}.
module packet_gen #(
  parameter logic [1:0]  SRC_PORT   = 2'd0,
  parameter logic [47:0] MAC_BASE   = 48'h02_00_00_00_00_00,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_pkts,
  input  logic [5:0]  pkt_len_blocks,
  input  logic [1:0]  dest_port,
  input  logic        rr_en,
  output logic [31:0] packet_out,
  output logic        packet_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] pkts_sent
);

  typedef enum logic [2:0] {IDLE, HDR, MAC_LO, SEQ, PAYLOAD, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [8:0]  word_cnt, word_n;
  logic [7:0]  gap_cnt, gap_n;
  logic [15:0] pkts_left, left_n;
  logic        unlim_q, unlim_n;
  logic [5:0]  len_q, len_n;
  logic [1:0]  port_q, port_n;
  logic        rr_q, rr_n;
  logic        stop_q, stop_n;
  logic [15:0] seq, seq_n;
  logic [15:0] sent_n;
  logic [31:0] out_n;
  logic        en_n, done_n, busy_n;
  logic [8:0]  last_idx;

`ifdef PKT_GEN_LFSR_EN
  logic [31:0] lfsr, lfsr_n;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
`endif

  assign last_idx = {len_q, 3'b000} - 9'd1;

  always_comb begin
    state_n = state;
    word_n  = word_cnt;
    gap_n   = gap_cnt;
    left_n  = pkts_left;
    unlim_n = unlim_q;
    len_n   = len_q;
    port_n  = port_q;
    rr_n    = rr_q;
    stop_n  = stop_q | (stop && (state != IDLE));
    seq_n   = seq;
    sent_n  = pkts_sent;
    out_n   = 32'h0;
    en_n    = 1'b0;
    done_n  = 1'b0;
`ifdef PKT_GEN_LFSR_EN
    lfsr_n  = lfsr;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_n = HDR;
          word_n  = 9'd0;
          len_n   = (pkt_len_blocks == 6'd0) ? 6'd1 : pkt_len_blocks;
          port_n  = dest_port;
          rr_n    = rr_en;
          unlim_n = (num_pkts == 16'd0);
          left_n  = num_pkts;
          stop_n  = stop;
        end
      end
      HDR: begin
        state_n = MAC_LO;
        word_n  = 9'd1;
      end
      MAC_LO: begin
        state_n = SEQ;
        word_n  = 9'd2;
      end
      SEQ: begin
        state_n = PAYLOAD;
        word_n  = 9'd3;
      end
      PAYLOAD: begin
        if (word_cnt == last_idx) begin
          seq_n  = seq + 16'd1;
          sent_n = pkts_sent + 16'd1;
          if (rr_q) port_n = port_q + 2'd1;
          if (!unlim_q) left_n = pkts_left - 16'd1;
          // A stop seen on the final word still ends the run here.
          if (stop_q || stop || (!unlim_q && (pkts_left == 16'd1))) begin
            state_n = IDLE;
            done_n  = 1'b1;
            stop_n  = 1'b0;
          end else if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n   = GAP_LAST;
          end else begin
            state_n = HDR;
            word_n  = 9'd0;
          end
        end else begin
          word_n = word_cnt + 9'd1;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_n = HDR;
          word_n  = 9'd0;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // The output word is built for the state being entered so it lands in the register with it.
    case (state_n)
      HDR: begin
        en_n  = 1'b1;
        out_n = {5'b0, len_n, SRC_PORT, 3'b0, MAC_BASE[47:32]};
      end
      MAC_LO: begin
        en_n  = 1'b1;
        out_n = {MAC_BASE[31:2], port_n};
      end
      SEQ: begin
        en_n  = 1'b1;
        out_n = {16'h0, seq_n};
      end
      PAYLOAD: begin
        en_n  = 1'b1;
`ifdef PKT_GEN_LFSR_EN
        out_n  = lfsr;
        lfsr_n = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
`else
        out_n  = {seq_n, 7'b0, word_n};
`endif
      end
      default: ;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word_cnt   <= 9'd0;
      gap_cnt    <= 8'd0;
      pkts_left  <= 16'd0;
      unlim_q    <= 1'b0;
      len_q      <= 6'd1;
      port_q     <= 2'd0;
      rr_q       <= 1'b0;
      stop_q     <= 1'b0;
      seq        <= 16'd0;
      pkts_sent  <= 16'd0;
      packet_out <= 32'h0;
      packet_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PKT_GEN_LFSR_EN
      lfsr       <= LFSR_SEED;
`endif
    end else begin
      state      <= state_n;
      word_cnt   <= word_n;
      gap_cnt    <= gap_n;
      pkts_left  <= left_n;
      unlim_q    <= unlim_n;
      len_q      <= len_n;
      port_q     <= port_n;
      rr_q       <= rr_n;
      stop_q     <= stop_n;
      seq        <= seq_n;
      pkts_sent  <= sent_n;
      packet_out <= out_n;
      packet_en  <= en_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef PKT_GEN_LFSR_EN
      lfsr       <= lfsr_n;
`endif
    end
  end

endmodule

// File: tb/tb_packet_gen.sv
// Bench for packet_gen: two instances (gap 2 and gap 0) checked cycle by cycle against a packet-list model.
module tb_packet_gen;

  localparam logic [1:0]  SRC  = 2'd1;
  localparam logic [47:0] MACB = 48'h02_AB_CD_EF_12_37;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, stop = 1'b0, rr_en = 1'b0;
  logic [15:0] num_pkts = 16'd0;
  logic [5:0]  pkt_len_blocks = 6'd0;
  logic [1:0]  dest_port = 2'd0;
  logic [31:0] out_a, out_b;
  logic        en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] sent_a, sent_b;

  int total = 0;
  int bad = 0;
  int seq_m[2];
  int sent_m[2];
  logic [31:0] lfsr_m[2];

  always #5 clk = ~clk;

  packet_gen #(.SRC_PORT(SRC), .MAC_BASE(MACB), .GAP_CYCLES(2), .LFSR_SEED(SEED)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop), .num_pkts(num_pkts),
    .pkt_len_blocks(pkt_len_blocks), .dest_port(dest_port), .rr_en(rr_en),
    .packet_out(out_a), .packet_en(en_a), .busy(busy_a), .done(done_a), .pkts_sent(sent_a));

  packet_gen #(.SRC_PORT(SRC), .MAC_BASE(MACB), .GAP_CYCLES(0), .LFSR_SEED(SEED)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop), .num_pkts(num_pkts),
    .pkt_len_blocks(pkt_len_blocks), .dest_port(dest_port), .rr_en(rr_en),
    .packet_out(out_b), .packet_en(en_b), .busy(busy_b), .done(done_b), .pkts_sent(sent_b));

  // x^32+x^22+x^2+x+1 in right-shifting Galois form
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      seq_m[s] = 0; sent_m[s] = 0; lfsr_m[s] = SEED;
    end
  endtask

  // stop_word < 0 with stop_pkt >= 0: stop is pulsed together with start.
  task automatic check_run(input int sel, input int num, input int len_in, input int dport,
                           input int rr, input int stop_pkt, input int stop_word, input int glitch_at);
    logic [31:0] ed[$];
    bit          ee[$];
    int gap, npk, stop_cyc, n, L, port, s;
    bit ok;
    logic [31:0] o, e_out;
    logic oen, obusy, odone, e_en;
    logic [15:0] osent;
    gap = (sel != 0) ? 0 : 2;
    L = (len_in == 0) ? 1 : len_in;
    npk = num;
    if (stop_pkt >= 0 && (num == 0 || stop_pkt + 1 < num)) npk = stop_pkt + 1;
    stop_cyc = -1;
    for (int p = 0; p < npk; p++) begin
      if (p == stop_pkt && stop_word >= 0) stop_cyc = ed.size() + stop_word;
      port = (rr != 0) ? ((dport + p) % 4) : dport;
      s = seq_m[sel] % 65536;
      ed.push_back(32'((L << 21) | (int'(SRC) << 19)) | 32'(MACB >> 32)); ee.push_back(1);
      ed.push_back((32'(MACB) & 32'hFFFF_FFFC) | 32'(port));               ee.push_back(1);
      ed.push_back(32'(s));                                                ee.push_back(1);
      for (int k = 3; k < 8 * L; k++) begin
`ifdef PKT_GEN_LFSR_EN
        ed.push_back(lfsr_m[sel]);
        lfsr_m[sel] = lfsr_next(lfsr_m[sel]);
`else
        ed.push_back(32'(s * 65536 + k));
`endif
        ee.push_back(1);
      end
      seq_m[sel]++;
      if (p < npk - 1)
        for (int g = 0; g < gap; g++) begin ed.push_back(32'h0); ee.push_back(0); end
    end
    sent_m[sel] += npk;
    n = ed.size();

    num_pkts = 16'(num); pkt_len_blocks = 6'(len_in); dest_port = 2'(dport); rr_en = (rr != 0);
    stop = (stop_pkt >= 0 && stop_word < 0);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    ok = 1'b1;
    for (int i = 0; i <= n + 1; i++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; stop = 1'b0;
      o     = (sel != 0) ? out_b  : out_a;
      oen   = (sel != 0) ? en_b   : en_a;
      obusy = (sel != 0) ? busy_b : busy_a;
      odone = (sel != 0) ? done_b : done_a;
      osent = (sel != 0) ? sent_b : sent_a;
      e_en  = (i < n) ? ee[i] : 1'b0;
      e_out = (i < n) ? ed[i] : 32'h0;
      if (ok) begin
        total++;
        if (oen !== e_en) begin
          bad++; ok = 1'b0;
          $display("FAIL packet_en dut%0d cycle %0d: got %b want %b", sel, i, oen, e_en);
        end
      end
      if (ok) begin
        total++;
        if (o !== e_out) begin
          bad++; ok = 1'b0;
          $display("FAIL packet_out dut%0d cycle %0d: got %08h want %08h", sel, i, o, e_out);
        end
      end
      if (ok) begin
        total++;
        if (obusy !== (i < n)) begin
          bad++; ok = 1'b0;
          $display("FAIL busy dut%0d cycle %0d: got %b want %b", sel, i, obusy, (i < n));
        end
      end
      if (ok) begin
        total++;
        if (odone !== (i == n)) begin
          bad++; ok = 1'b0;
          $display("FAIL done dut%0d cycle %0d: got %b want %b", sel, i, odone, (i == n));
        end
      end
      if (ok && i == n) begin
        total++;
        if (osent !== 16'(sent_m[sel])) begin
          bad++; ok = 1'b0;
          $display("FAIL pkts_sent dut%0d: got %0d want %0d", sel, osent, sent_m[sel] % 65536);
        end
      end
      if (i == stop_cyc) stop = 1'b1;
      if (i == glitch_at) begin
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        dest_port = 2'(dport + 1);
        num_pkts = 16'(num + 5);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({out_a, en_a, busy_a, done_a, sent_a} !== 51'h0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {out_a, en_a, busy_a, done_a, sent_a});
    end
    total++;
    if ({out_b, en_b, busy_b, done_b, sent_b} !== 51'h0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {out_b, en_b, busy_b, done_b, sent_b});
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single();       check_run(0, 1, 1, 2, 0, -1, -1, -1); endtask
  task automatic test_rr_gap();       check_run(0, 3, 2, 3, 1, -1, -1, 5);  endtask
  task automatic test_stop();         check_run(0, 0, 1, 2, 0, 4, 5, -1);   endtask
  task automatic test_stop_start();   check_run(0, 3, 2, 1, 0, 0, -1, -1);  endtask

  task automatic test_len_bounds();
    check_run(0, 1, 0, 0, 0, -1, -1, -1);
    check_run(1, 1, 63, 1, 0, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    check_run(1, 3, 1, 0, 1, -1, -1, 4);
    check_run(1, 0, 2, 2, 1, 2, 9, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      check_run(int'($urandom_range(1, 0)), int'($urandom_range(3, 1)), int'($urandom_range(5, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(1, 0)), -1, -1,
                int'($urandom_range(12, 0)));
  endtask

  task automatic test_midreset();
    num_pkts = 16'd2; pkt_len_blocks = 6'd2; dest_port = 2'd1; rr_en = 1'b0;
    start_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({en_a, busy_a, out_a, sent_a} !== 50'h0) begin
      bad++; $display("FAIL midreset_async: got %h want 0", {en_a, busy_a, out_a, sent_a});
    end
    @(negedge clk);
    total++;
    if ({en_a, busy_a, done_a} !== 3'b000) begin
      bad++; $display("FAIL midreset_hold: got %b want 000", {en_a, busy_a, done_a});
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_run(0, 1, 1, 0, 0, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_gap();
    test_stop();
    test_stop_start();
    test_len_bounds();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
